// File: rtl/fp16_feeder_pkg.sv
// ----------------------------------------------------------------------------
// fp16_feeder_pkg
//   Shared types and helpers for the FP16 MAC operand feeder.
//   - state_e      : feeder FSM states
//   - FP16_ZERO    : canonical +0.0 encoding
//   - FP16_ONE     : +1.0 encoding
//   - fp16_is_zero : true for +0.0 or -0.0 (sign bit ignored)
// ----------------------------------------------------------------------------
package fp16_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_e;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    function automatic logic fp16_is_zero(input logic [15:0] v);
        return (v[14:0] == 15'd0);
    endfunction

endpackage

// File: rtl/fp16_mac_operand_feeder.sv
// ----------------------------------------------------------------------------
// fp16_mac_operand_feeder
//   Initiator side of the FP16 approximate MAC interface. For each dot-product
//   command of length N it clears the MAC, streams N operand pairs into it,
//   waits out the MAC latency and captures the accumulator as one result.
//
//   Parameters: DATA_W (operand width), LEN_W (cmd_len width),
//               MAC_LAT (cycles from a mac_enable cycle to mac_acc update, >=1)
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     cmd_valid/cmd_ready/cmd_len command handshake, N pairs (0 allowed)
//     op_valid/op_ready/op_a/op_b operand pair handshake
//     mac_clear/mac_enable        MAC control strobes
//     mac_a/mac_b                 MAC operands (valid with mac_enable)
//     mac_acc                     MAC accumulator input
//     res_valid/res_ready/res_data result handshake
//     busy                        high whenever the FSM is not IDLE
//
//   Build option FP16_FEEDER_ZERO_SKIP_EN: pairs where either operand is +/-0
//   are consumed without issuing mac_enable.
// ----------------------------------------------------------------------------
module fp16_mac_operand_feeder
    import fp16_feeder_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              mac_clear,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy
);

    // Drain counter holds the cycles still to wait before mac_acc reflects
    // the most recent clear/enable; values range 0..MAC_LAT-1.
    localparam int               CNT_W  = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MAC_LAT - 1);

    state_e              state_q;
    logic [LEN_W-1:0]    remaining_q;
    logic [CNT_W-1:0]    drain_q;
    logic                cmd_ready_q;
    logic                op_ready_q;
    logic                mac_clear_q;
    logic                mac_enable_q;
    logic [DATA_W-1:0]   mac_a_q;
    logic [DATA_W-1:0]   mac_b_q;
    logic                res_valid_q;
    logic [DATA_W-1:0]   res_data_q;
    logic                busy_q;
    logic                issue_d;

    // Whether an accepted pair actually reaches the MAC.
`ifdef FP16_FEEDER_ZERO_SKIP_EN
    assign issue_d = !(fp16_is_zero(op_a) || fp16_is_zero(op_b));
`else
    assign issue_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            drain_q      <= '0;
            cmd_ready_q  <= 1'b1;
            op_ready_q   <= 1'b0;
            mac_clear_q  <= 1'b0;
            mac_enable_q <= 1'b0;
            mac_a_q      <= FP16_ZERO;
            mac_b_q      <= FP16_ZERO;
            res_valid_q  <= 1'b0;
            res_data_q   <= FP16_ZERO;
            busy_q       <= 1'b0;
        end else begin
            mac_clear_q  <= 1'b0;
            mac_enable_q <= 1'b0;

            // Restart the latency wait on every MAC event, so DRAIN always
            // times from the last real clear/enable (zero-skipped pairs
            // do not count as events).
            if (mac_clear_q || mac_enable_q) begin
                drain_q <= LAT_M1;
            end else if (drain_q != '0) begin
                drain_q <= drain_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        remaining_q <= cmd_len;
                        mac_clear_q <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (remaining_q != '0) begin
                        op_ready_q <= 1'b1;
                        state_q    <= STREAM;
                    end else begin
                        state_q    <= DRAIN;
                    end
                end
                STREAM: begin
                    if (op_valid && op_ready_q) begin
                        mac_a_q      <= op_a;
                        mac_b_q      <= op_b;
                        mac_enable_q <= issue_d;
                        remaining_q  <= remaining_q - 1'b1;
                        // op_ready drops on the same edge as the last
                        // accept so no pair beyond N is taken.
                        if (remaining_q == LEN_W'(1)) begin
                            op_ready_q <= 1'b0;
                            state_q    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // An enable issued this cycle is not yet in mac_acc.
                    if (!mac_enable_q && (drain_q == '0)) begin
                        res_data_q  <= mac_acc;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign op_ready   = op_ready_q;
    assign mac_clear  = mac_clear_q;
    assign mac_enable = mac_enable_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fp16_mac_operand_feeder.sv
// ----------------------------------------------------------------------------
// tb_fp16_mac_operand_feeder
//   Directed bench for fp16_mac_operand_feeder driving a behavioural FP16 MAC
//   (one-cycle latency, exact for the operand values used here).
// ----------------------------------------------------------------------------
module tb_fp16_mac_operand_feeder;

`ifdef FP16_FEEDER_ZERO_SKIP_EN
    localparam int ZS_EN = 2;
`else
    localparam int ZS_EN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mac_clear;
    logic        mac_enable;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [15:0] mac_acc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_hs_tot  = 0;
    int n_en_tot  = 0;
    int n_clr_tot = 0;

    logic [15:0] a_tab [0:15];
    logic [15:0] b_tab [0:15];

    always #5 clk = ~clk;

    fp16_mac_operand_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mac_clear  (mac_clear),
        .mac_enable (mac_enable),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc    (mac_acc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    function automatic real f2r(input logic [15:0] h);
        real m;
        int  e;
        if (h[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return h[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2h(input real v);
        logic s;
        int   e;
        int   mant;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        if (s) v = -v;
        e = 15;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        mant = $rtoi((v - 1.0) * 1024.0 + 0.5);
        if (mant == 1024) begin mant = 0; e++; end
        return {s, e[4:0], mant[9:0]};
    endfunction

    // Behavioural MAC: clear (or reset) zeroes, enable accumulates a*b.
    always @(posedge clk) begin
        if (rst || mac_clear) mac_acc <= 16'h0000;
        else if (mac_enable)  mac_acc <= r2h(f2r(mac_acc) + f2r(mac_a) * f2r(mac_b));
    end

    always @(negedge clk) begin
        if (op_valid && op_ready) n_hs_tot  <= n_hs_tot + 1;
        if (mac_enable)           n_en_tot  <= n_en_tot + 1;
        if (mac_clear)            n_clr_tot <= n_clr_tot + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_cmd(input string tag, input int n, input bit toggle,
                          input int exp_en, input logic [15:0] exp_res, input int hold);
        int h0, e0, c0, idx, cyc, bad;
        bit hs;
        logic [15:0] pa, pb;
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        h0 = n_hs_tot; e0 = n_en_tot; c0 = n_clr_tot;
        cmd_valid = 1'b1;
        cmd_len   = n[7:0];
        tick();
        cmd_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        idx = 0; cyc = 0; bad = 0;
        while (idx < n && cyc < 400) begin
            op_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            op_a = a_tab[idx];
            op_b = b_tab[idx];
            hs = op_valid && op_ready;
            pa = mac_a; pb = mac_b;
            tick();
            if (toggle && !mac_enable && (mac_a !== pa || mac_b !== pb)) bad++;
            if (hs) idx++;
            cyc++;
        end
        if (toggle) check({tag, "_bubble_hold"}, bad, 0);
        // Keep offering pairs: none may be accepted beyond N.
        op_valid = 1'b1;
        op_a = 16'h3C00;
        op_b = 16'h3C00;
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        op_valid = 1'b0;
        check({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_handshakes"}, n_hs_tot - h0, n);
        check({tag, "_enables"}, n_en_tot - e0, exp_en);
        check({tag, "_clears"}, n_clr_tot - c0, 1);
        check({tag, "_res_data"}, {16'd0, res_data}, {16'd0, exp_res});
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!(res_valid === 1'b1 && res_data === exp_res && cmd_ready === 1'b0 && busy === 1'b1))
                bad++;
        end
        if (hold > 0) check({tag, "_hold"}, bad, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_res_valid_drop"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int idx, cyc;
        bit hs;
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'd0; op_valid = 1'b0;
        op_a = 16'h0; op_b = 16'h0; res_ready = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_ctrl", {26'd0, cmd_ready, op_ready, mac_clear, mac_enable, res_valid, busy},
              {26'd0, 6'b100000});
        check("rst_data", {mac_a, mac_b}, 32'd0);
        check("rst_res", {16'd0, res_data}, 32'd0);
        rst = 1'b0;
        tick();

        // 1 + 4: N=3 of 1.0*1.0, result held 5 cycles before consume
        for (int i = 0; i < 3; i++) begin a_tab[i] = 16'h3C00; b_tab[i] = 16'h3C00; end
        do_cmd("t1", 3, 1'b0, 3, 16'h4200, 5);

        // 2: N=0 gives cleared accumulator
        do_cmd("t2", 0, 1'b0, 0, 16'h0000, 0);

        // 3: N=10 of 0.5*0.5 with op_valid toggling
        for (int i = 0; i < 10; i++) begin a_tab[i] = 16'h3800; b_tab[i] = 16'h3800; end
        do_cmd("t3", 10, 1'b1, 10, 16'h4100, 0);

        // 5: reset after 2 of 10 pairs
        cmd_valid = 1'b1; cmd_len = 8'd10;
        tick();
        cmd_valid = 1'b0;
        idx = 0; cyc = 0;
        while (idx < 2 && cyc < 50) begin
            op_valid = 1'b1; op_a = 16'h3C00; op_b = 16'h3C00;
            hs = op_valid && op_ready;
            tick();
            if (hs) idx++;
            cyc++;
        end
        check("t5_two_pairs", idx, 2);
        op_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("t5_rst_ctrl", {26'd0, cmd_ready, op_ready, mac_clear, mac_enable, res_valid, busy},
              {26'd0, 6'b100000});
        check("t5_rst_data", {mac_a, mac_b}, 32'd0);
        check("t5_rst_res", {16'd0, res_data}, 32'd0);
        rst = 1'b0;
        tick();
        a_tab[0] = 16'h4000; b_tab[0] = 16'h4000;
        do_cmd("t5", 1, 1'b0, 1, 16'h4400, 0);

        // 6: zero operands
        a_tab[0] = 16'h0000; b_tab[0] = 16'h3C00;
        a_tab[1] = 16'h3C00; b_tab[1] = 16'h3C00;
        a_tab[2] = 16'h4000; b_tab[2] = 16'h0000;
        a_tab[3] = 16'h3C00; b_tab[3] = 16'h3C00;
        do_cmd("t6", 4, 1'b0, ZS_EN, 16'h4000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
